// File: rtl/sub_escritura_if.sv
// Product handshake into the display stage: producer offers a signed Booth product,
// the display stage raises ready only while it is idle.
interface sub_escritura_if #(
   parameter int ancho = 4
);
   logic                 valid;
   logic [2*ancho-1:0]   producto;
   logic                 ready;

   modport master (output valid, output producto, input ready);
   modport slave  (input valid, input producto, output ready);
endinterface

// File: rtl/sub_escritura.sv
// Signed product -> sequential double-dabble BCD -> multiplexed common-anode 7-segment scan.
// Latency: transfer edge + 2*ancho + 1 to display registers, +1 to seg/an; ready low meanwhile.
module sub_escritura #(
   parameter int ancho   = 4,
   parameter int N_DIG   = 3,
   parameter int REFRESH = 50000
) (
   input  logic             clk,
   input  logic             rst,
   sub_escritura_if.slave   bus,
   output logic [6:0]       seg,
   output logic [N_DIG:0]   an
);
   localparam int W  = 2*ancho;
   localparam int B  = 4*N_DIG;
   localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
   localparam int IW = $clog2(N_DIG+1);
   localparam int NW = $clog2(W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_UPD  = 2'd2;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     mag_q, mag_d;
   logic             neg_q, neg_d;
   logic [B-1:0]     bcd_q, bcd_d, bcd_adj;
   logic [B+W-1:0]   dd_shift;
   logic [NW-1:0]    it_q, it_d;
   logic [B-1:0]     disp_q, disp_d;
   logic             dneg_q, dneg_d;
   logic [CW-1:0]    ref_q, ref_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [N_DIG:0]   an_q, an_d;
   logic [B-1:0]     shifted;
   logic [3:0]       digit;
   logic             xfer;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   assign bus.ready = (state_q == S_IDLE);
   assign xfer      = bus.valid && bus.ready;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < N_DIG; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      dd_shift = {bcd_adj, mag_q} << 1;

      state_d = state_q;
      mag_d   = mag_q;
      neg_d   = neg_q;
      bcd_d   = bcd_q;
      it_d    = it_q;
      disp_d  = disp_q;
      dneg_d  = dneg_q;

      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               neg_d   = bus.producto[W-1];
               // The most negative value negates to itself, which read unsigned is its magnitude.
               mag_d   = bus.producto[W-1] ? (~bus.producto + W'(1)) : bus.producto;
               bcd_d   = '0;
               it_d    = '0;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            bcd_d = dd_shift[B+W-1:W];
            mag_d = dd_shift[W-1:0];
            it_d  = it_q + 1'b1;
            if (it_q == NW'(W-1))
               state_d = S_UPD;
         end
         S_UPD: begin
            disp_d  = bcd_q;
            dneg_d  = neg_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
      if (ref_q == CW'(REFRESH-1)) begin
         ref_d = '0;
         idx_d = (idx_q == IW'(N_DIG)) ? '0 : idx_q + 1'b1;
      end

      shifted = disp_q >> (4*idx_q);
      digit   = shifted[3:0];
      // A digit is a leading zero when it and everything above it are zero.
      if (idx_q == IW'(N_DIG))
         seg_d = (dneg_q && (disp_q != '0)) ? SEG_DASH : SEG_BLANK;
      else if ((idx_q != '0) && (shifted == '0))
         seg_d = SEG_BLANK;
      else
         seg_d = seg7(digit);

      an_d = '1;
      for (int i = 0; i <= N_DIG; i++)
         an_d[i] = (idx_q != IW'(i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         bcd_q   <= '0;
         it_q    <= '0;
         disp_q  <= '0;
         dneg_q  <= 1'b0;
         ref_q   <= '0;
         idx_q   <= '0;
         seg_q   <= '1;
         an_q    <= '1;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         bcd_q   <= bcd_d;
         it_q    <= it_d;
         disp_q  <= disp_d;
         dneg_q  <= dneg_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
endmodule

// File: tb/tb_sub_escritura.sv
// Scoreboard bench: stimulus queues the expected display per transfer; monitor scans the display.
module tb_sub_escritura;
   localparam int ANCHO   = 4;
   localparam int N_DIG   = 3;
   localparam int REFRESH = 4;

   localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
   localparam logic [6:0] D5 = 7'b0010010, D7 = 7'b1111000, D8 = 7'b0000000;
   localparam logic [6:0] DASH = 7'b0111111, BL = 7'b1111111;

   typedef struct packed {
      logic            chk_len;
      logic [3:0][6:0] s;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_seen = 1'b0;
   logic [6:0] seg;
   logic [N_DIG:0] an;
   int n_cmp = 0;
   int n_bad = 0;
   bit mon_busy = 1'b0;
   exp_t q[$];

   sub_escritura_if #(.ancho(ANCHO)) bus();

   sub_escritura #(.ancho(ANCHO), .N_DIG(N_DIG), .REFRESH(REFRESH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .seg (seg),
      .an  (an)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rst_seen <= rst;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input bit cl, input logic [6:0] s3, s2, s1, s0);
      exp_t e;
      e.chk_len = cl;
      e.s[3] = s3; e.s[2] = s2; e.s[1] = s1; e.s[0] = s0;
      return e;
   endfunction

   task automatic scan(input exp_t e);
      logic [6:0] got [4];
      bit seen [4];
      logic [3:0] prev;
      int run, ntr, bad_oh;
      for (int p = 0; p < 4; p++) begin got[p] = '0; seen[p] = 1'b0; end
      prev = '0; run = 0; ntr = 0; bad_oh = 0;
      @(negedge clk);
      for (int k = 0; k < (N_DIG+1)*REFRESH + 2; k++) begin
         if (k > 0) @(negedge clk);
         if ($countones(~an) != 1) bad_oh++;
         for (int p = 0; p < 4; p++)
            if (an == ~(4'b0001 << p)) begin got[p] = seg; seen[p] = 1'b1; end
         if (k > 0 && an != prev) begin
            chk("an_order", an, {prev[2:0], prev[3]});
            if (ntr > 0) chk("an_dwell", run, REFRESH);
            ntr++;
            run = 1;
         end else begin
            run++;
         end
         prev = an;
      end
      chk("an_onehot_violations", bad_oh, 0);
      for (int p = 0; p < 4; p++)
         chk($sformatf("seg_pos%0d", p), {seen[p], got[p]}, {1'b1, e.s[p]});
   endtask

   initial begin : monitor
      int low_cnt;
      bit pend;
      exp_t e;
      low_cnt = 0;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_seen) begin
            chk("rst_seg", seg, 7'h7F);
            chk("rst_an", an, 4'hF);
            pend = 1'b1;
            low_cnt = 0;
         end else if (!bus.ready) begin
            low_cnt++;
         end else if (pend || low_cnt > 0) begin
            mon_busy = 1'b1;
            chk("sb_has_entry", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               if (e.chk_len) chk("ready_low_cycles", low_cnt, 2*ANCHO+1);
               scan(e);
            end
            pend = 1'b0;
            low_cnt = 0;
            mon_busy = 1'b0;
         end
      end
   end

   task automatic wait_rdy();
      int n = 0;
      while (!bus.ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!bus.ready) chk("wait_ready_timeout", bus.ready, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((q.size() != 0 || mon_busy) && n < 300) begin @(posedge clk); #1; n++; end
      if (q.size() != 0 || mon_busy) chk("done_timeout", q.size(), 0);
   endtask

   task automatic send(input logic [7:0] p, input exp_t e);
      wait_rdy();
      q.push_back(e);
      bus.producto = p;
      bus.valid = 1'b1;
      @(posedge clk); #1;
      bus.valid = 1'b0;
   endtask

   initial begin : stim
      bus.valid = 1'b0;
      bus.producto = '0;
      q.push_back(mk(0, BL, BL, BL, D0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_done();

      send(8'h7F, mk(1, BL,   D1, D2, D7)); wait_done();
      send(8'h80, mk(1, DASH, D1, D2, D8)); wait_done();
      send(8'hFB, mk(1, DASH, BL, BL, D5)); wait_done();
      send(8'h00, mk(1, BL,   BL, BL, D0)); wait_done();
      send(8'hF6, mk(1, DASH, BL, D1, D0)); wait_done();
      send(8'h64, mk(1, BL,   D1, D0, D0)); wait_done();

      // Second offer during conversion must be dropped.
      wait_rdy();
      q.push_back(mk(1, BL, BL, D1, D2));
      bus.producto = 8'h0C;
      bus.valid = 1'b1;
      @(posedge clk); #1;
      bus.producto = 8'h21;
      repeat (3) @(posedge clk);
      #1 bus.valid = 1'b0;
      wait_done();

      // Reset in the middle of converting 99.
      send(8'h63, mk(0, BL, BL, BL, D0));
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("ready_after_rst", bus.ready, 1);
      wait_done();

      // Reset and valid together: no transfer may start.
      wait_rdy();
      q.push_back(mk(0, BL, BL, BL, D0));
      rst = 1'b1;
      bus.producto = 8'h7F;
      bus.valid = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.valid = 1'b0;
      chk("rst_beats_valid_ready", bus.ready, 1);
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sub_escritura.md
Name: sub_escritura

Overview:
Output-side counterpart of the input read/synchronizer stage of the Booth multiplier datapath. It accepts the signed 2*ancho-bit product through a valid/ready handshake and converts its magnitude to BCD with a sequential double-dabble engine. It then drives a time-multiplexed, common-anode 7-segment display: one sign position plus N_DIG decimal digits.

Parameters:
ancho, 4, Booth operand width; the product is 2*ancho bits, two's complement.
N_DIG, 3, number of decimal digits; must satisfy 10^N_DIG > 2^(2*ancho-1).
REFRESH, 50000, clock cycles each display position stays active; must be >= 1.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous, active-high reset.
valid  input  1  product on producto is valid this cycle.
producto  input  2*ancho  signed Booth product.
ready  output  1  block can accept a product (high only in IDLE).
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
an  output  N_DIG+1  position enable, active-low one-hot; bit 0 = units, bit N_DIG = sign.

Behaviour:
- Reset (rst high at a posedge):
  - FSM goes to IDLE; ready=1.
  - Displayed digits and the sign flag are cleared, so the display shows "0" in units.
  - Refresh counter and position index are set to 0.
  - seg and an are registered outputs; both take all-ones in the reset cycle.
  - Reset mid-conversion aborts the conversion. No partial result is ever displayed.
- Handshake:
  - A transfer occurs at a posedge with valid=1 and ready=1.
  - valid while ready=0 is ignored; there is no queue.
  - producto is sampled only at the transfer edge.
- FSM, IDLE -> CONV -> UPDATE -> IDLE:
  - IDLE: on transfer, latch neg = producto MSB and mag = |producto| as a 2*ancho-bit unsigned value. -2^(2*ancho-1) maps to 2^(2*ancho-1) with no overflow. Clear the BCD accumulator and the bit counter. Go to CONV.
  - CONV: one double-dabble iteration per cycle. Each BCD nibble >= 5 gets +3, then {bcd, mag} shifts left by one. After exactly 2*ancho iterations, go to UPDATE.
  - UPDATE: copy BCD and neg into the display registers in a single cycle (atomic), then go to IDLE.
- Timing:
  - ready is low for exactly 2*ancho+1 cycles after the transfer edge.
  - The new value is visible in the display registers at transfer edge + 2*ancho + 1.
  - The old value is displayed until then.
- Display formatting:
  - Leading zeros are blanked; the units digit is always shown.
  - The sign position shows '-' when neg=1 and the value is nonzero, otherwise blank.
  - "-0" never appears.
- Encodings (active-low gfedcba):

| Symbol | Code |
|---|---|
| 0 | 1000000 |
| 1 | 1111001 |
| 2 | 0100100 |
| 3 | 0110000 |
| 4 | 0011001 |
| 5 | 0010010 |
| 6 | 0000010 |
| 7 | 1111000 |
| 8 | 0000000 |
| 9 | 0010000 |
| '-' | 0111111 |
| blank | 1111111 |

- Scanning:
  - The refresh counter runs 0..REFRESH-1 continuously and independently of the FSM, including during conversion.
  - At wrap, the position index advances 0,1,...,N_DIG,0.
  - seg/an are registered from the current index and display registers, giving one cycle of latency.
  - an has exactly one low bit at all times outside reset.
- Simultaneous rst and valid: rst wins and no transfer occurs.

Test Plan:
1. Reset, then hold valid=0 with REFRESH=4 -> an cycles 1110, 1101, 1011, 0111, changing every 4 cycles. seg=1000000 at units, 1111111 at the other positions.
2. producto=8'h7F, valid for one cycle -> ready low 9 cycles. Display then reads blank/1/2/7: seg 1111111, 1111001, 0100100, 1111000 at an bits 3..0.
3. producto=8'h80 -> positions read '-',1,2,8: seg 0111111, 1111001, 0100100, 0000000.
4. producto=8'hFB (-5) -> '-' in the sign position, blanks at hundreds and tens, 0010010 at units. Then producto=8'h00 -> sign blank, units '0'.
5. Accept 8'h0C (12), then assert valid with 8'h21 during CONV -> the second value is ignored, the display shows 12, and ready returns high after 9 cycles.
6. Accept 8'h63 (99), assert rst at cycle 4 of CONV -> ready=1 next cycle and the display shows "0"; 99 never appears.
